// File: rtl/dmem_pkg.sv
// Shared definitions for the dmem load/store unit: dmem memop codes, RV32 funct3
// codes, the sequencer state type and the funct3 decode helpers.
package dmem_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] MEMOP_W  = 3'b000;
    localparam logic [2:0] MEMOP_B  = 3'b001;
    localparam logic [2:0] MEMOP_H  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b101;
    localparam logic [2:0] MEMOP_HU = 3'b110;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SAMPLE,
        ST_COMMIT,
        ST_RESP
    } lsu_state_e;

    typedef struct packed {
        logic       legal;
        logic [2:0] memop;
    } memop_dec_t;

    function automatic memop_dec_t decode_funct3(input logic is_store, input logic [2:0] funct3);
        memop_dec_t dec;
        dec.legal = 1'b1;
        dec.memop = MEMOP_W;
        if (is_store) begin
            case (funct3)
                F3_SB:   dec.memop = MEMOP_B;
                F3_SH:   dec.memop = MEMOP_H;
                F3_SW:   dec.memop = MEMOP_W;
                default: dec.legal = 1'b0;
            endcase
        end else begin
            case (funct3)
                F3_LB:   dec.memop = MEMOP_B;
                F3_LH:   dec.memop = MEMOP_H;
                F3_LW:   dec.memop = MEMOP_W;
                F3_LBU:  dec.memop = MEMOP_BU;
                F3_LHU:  dec.memop = MEMOP_HU;
                default: dec.legal = 1'b0;
            endcase
        end
        return dec;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] memop, input logic [1:0] addr_lo);
        logic mis;
        case (memop)
            MEMOP_H, MEMOP_HU: mis = addr_lo[0];
            MEMOP_W:           mis = (addr_lo != 2'b00);
            default:           mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_lsu.sv
// Multi-cycle load/store sequencer in front of the byte-masked RMW dmem:
// one request at a time, registered rdclk/wrclk strobes, single response pulse.
module dmem_lsu
    import dmem_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_misaligned,
    output logic            resp_illegal,
    output logic [XLEN-1:0] dmemaddr,
    output logic [XLEN-1:0] dmemdatain,
    input  logic [XLEN-1:0] dmemdataout,
    output logic            dmemrdclk,
    output logic            dmemwrclk,
    output logic [2:0]      dmemop,
    output logic            dmemwe
);

    lsu_state_e      state_q;
    logic            req_ready_q;
    logic            resp_valid_q;
    logic [XLEN-1:0] resp_rdata_q;
    logic            resp_mis_q;
    logic            resp_ill_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [2:0]      op_q;
    logic            rdclk_q;
    logic            wrclk_q;
    logic            we_q;

    // Decode only feeds flop D inputs; strobes never see a combinational input path.
    memop_dec_t req_dec;
    logic       req_mis;
    logic       req_ill;

    assign req_dec = decode_funct3(req_we, req_funct3);
    assign req_ill = ~req_dec.legal;
    assign req_mis = req_dec.legal & is_misaligned(req_dec.memop, req_addr[1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_mis_q   <= 1'b0;
            resp_ill_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            op_q         <= '0;
            rdclk_q      <= 1'b0;
            wrclk_q      <= 1'b0;
            we_q         <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready_q  <= 1'b0;
                        resp_rdata_q <= '0;
                        if (req_ill || req_mis) begin
                            resp_valid_q <= 1'b1;
                            resp_ill_q   <= req_ill;
                            resp_mis_q   <= req_mis;
                            state_q      <= ST_RESP;
                        end else begin
                            addr_q  <= req_addr;
                            wdata_q <= req_wdata;
                            op_q    <= req_dec.memop;
                            we_q    <= req_we;
                            rdclk_q <= 1'b1;
                            state_q <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    // Falling rdclk lets dmem capture q (load) or the old word (store).
                    rdclk_q <= 1'b0;
                    state_q <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    if (we_q) begin
                        wrclk_q <= 1'b1;
                        state_q <= ST_COMMIT;
                    end else begin
                        resp_rdata_q <= dmemdataout;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESP;
                    end
                end
                ST_COMMIT: begin
                    wrclk_q      <= 1'b0;
                    we_q         <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_rdata_q <= '0;
                    resp_mis_q   <= 1'b0;
                    resp_ill_q   <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    rdclk_q     <= 1'b0;
                    wrclk_q     <= 1'b0;
                    we_q        <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready       = req_ready_q;
    assign resp_valid      = resp_valid_q;
    assign resp_rdata      = resp_rdata_q;
    assign resp_misaligned = resp_mis_q;
    assign resp_illegal    = resp_ill_q;
    assign dmemaddr        = addr_q;
    assign dmemdatain      = wdata_q;
    assign dmemop          = op_q;
    assign dmemrdclk       = rdclk_q;
    assign dmemwrclk       = wrclk_q;
    assign dmemwe          = we_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized bench for dmem_lsu: a word-wide dmem stand-in driven by the strobes,
// checked against a byte-array reference model of RV32 load/store semantics.
module tb_dmem_lsu;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_illegal;
    logic [31:0] dmemaddr;
    logic [31:0] dmemdatain;
    logic [31:0] dmemdataout;
    logic        dmemrdclk;
    logic        dmemwrclk;
    logic [2:0]  dmemop;
    logic        dmemwe;

    int checks   = 0;
    int failures = 0;

    dmem_lsu u_dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .resp_illegal    (resp_illegal),
        .dmemaddr        (dmemaddr),
        .dmemdatain      (dmemdatain),
        .dmemdataout     (dmemdataout),
        .dmemrdclk       (dmemrdclk),
        .dmemwrclk       (dmemwrclk),
        .dmemop          (dmemop),
        .dmemwe          (dmemwe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 0) return 32'h8000_7FF0;
        return 32'h9E37_79B9 * (i + 1);
    endfunction

    // dmem stand-in: 16 words at 0x100, read on rdclk fall, masked write on wrclk rise
    logic [31:0] mem_w [0:15];
    logic [31:0] tempout;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int we_cycles = 0;
    int wr_bad = 0;

    function automatic logic [31:0] dmem_read(input logic [31:0] w, input logic [2:0] op, input logic [1:0] a);
        logic [31:0] s;
        s = w >> (8 * a);
        case (op)
            3'b001:  return {{24{s[7]}}, s[7:0]};
            3'b010:  return {{16{s[15]}}, s[15:0]};
            3'b101:  return {24'h0, s[7:0]};
            3'b110:  return {16'h0, s[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] dmem_merge(input logic [31:0] old, input logic [31:0] din,
                                               input logic [2:0] op, input logic [1:0] a);
        logic [31:0] w;
        w = old;
        case (op)
            3'b001:  w[8*a +: 8] = din[7:0];
            3'b010:  w[8*a +: 16] = din[15:0];
            default: w = din;
        endcase
        return w;
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) mem_w[i] = init_word(i);
        forever begin
            @(posedge dmemwrclk);
            wr_cnt++;
            if (dmemwe !== 1'b1) wr_bad++;
            mem_w[dmemaddr[5:2]] = dmem_merge(tempout, dmemdatain, dmemop, dmemaddr[1:0]);
        end
    end

    always @(negedge dmemrdclk) begin
        if (dmemwe) tempout = mem_w[dmemaddr[5:2]];
        else        dmemdataout = dmem_read(mem_w[dmemaddr[5:2]], dmemop, dmemaddr[1:0]);
    end

    always @(posedge dmemrdclk) rd_cnt++;
    always @(posedge clk) if (dmemwe === 1'b1) we_cycles++;

    // Reference model: plain byte array, RV32 rules stated directly
    logic [7:0] ref_b [0:63];

    task automatic ref_access(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic [31:0] rdata,
                              output bit mis, output bit ill);
        int size;
        int off;
        logic [31:0] val;
        size  = 1 << f3[1:0];
        off   = int'(addr) - 32'h100;
        ill   = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
        mis   = !ill && ((int'(addr) % size) != 0);
        rdata = 32'h0;
        if (!ill && !mis) begin
            if (we) begin
                for (int i = 0; i < size; i++) ref_b[off + i] = wdata[8*i +: 8];
            end else begin
                val = 32'h0;
                for (int i = 0; i < size; i++) val = val | (32'(ref_b[off + i]) << (8 * i));
                if (!f3[2] && size < 4 && val[8*size - 1]) val = val | (32'hFFFF_FFFF << (8 * size));
                rdata = val;
            end
        end
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called #1 after a clock edge; returns #1 after the edge that raised resp_valid.
    task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit hold, input bit b2b);
        logic [31:0] er;
        bit em, ei, rdy;
        int rd0, wr0, we0, waits, lat, exp_lat;
        rd0 = rd_cnt; wr0 = wr_cnt; we0 = we_cycles;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        for (waits = 1; waits <= 20; waits++) begin
            rdy = req_ready;
            @(posedge clk);
            if (rdy) break;
            #1;
        end
        if (waits > 20) begin
            check_eq("accept_timeout", 32'd0, 32'd1);
            #1;
            req_valid = 1'b0;
            return;
        end
        ref_access(we, f3, addr, wdata, er, em, ei);
        if (b2b) check_eq("b2b_accept_wait", waits, 2);
        #1;
        if (!hold) req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        exp_lat = (em || ei) ? 1 : (we ? 4 : 3);
        check_eq("latency", lat, exp_lat);
        check_eq("rdata", resp_rdata, er);
        check_eq("misaligned", resp_misaligned, em);
        check_eq("illegal", resp_illegal, ei);
        check_eq("rdclk_pulses", rd_cnt - rd0, (em || ei) ? 0 : 1);
        check_eq("wrclk_pulses", wr_cnt - wr0, (!em && !ei && we) ? 1 : 0);
        check_eq("we_cycles", we_cycles - we0, (!em && !ei && we) ? 3 : 0);
        $display("txn we=%0d f3=%0d addr=%h wdata=%h rdata=%h mis=%0d ill=%0d lat=%0d",
                 we, f3, addr, wdata, resp_rdata, resp_misaligned, resp_illegal, lat);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_ready", req_ready, 1);
        check_eq("rst_resp_valid", resp_valid, 0);
        check_eq("rst_rdata", resp_rdata, 0);
        check_eq("rst_flags", {resp_misaligned, resp_illegal}, 0);
        check_eq("rst_addr", dmemaddr, 0);
        check_eq("rst_datain", dmemdatain, 0);
        check_eq("rst_op", dmemop, 0);
        check_eq("rst_strobes", {dmemrdclk, dmemwrclk, dmemwe}, 0);
    endtask

    initial begin
        logic [2:0] f3;
        bit we;
        int wr0;
        for (int i = 0; i < 16; i++)
            for (int b = 0; b < 4; b++) ref_b[4*i + b] = init_word(i) >> (8 * b);
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b0;
        @(posedge clk); #1;

        do_req(1'b0, 3'b000, 32'h103, 32'h0, 1'b0, 1'b0);           // lb
        do_req(1'b0, 3'b101, 32'h102, 32'h0, 1'b0, 1'b0);           // lhu
        do_req(1'b0, 3'b001, 32'h100, 32'h0, 1'b0, 1'b0);           // lh
        do_req(1'b1, 3'b000, 32'h101, 32'h0000_00AB, 1'b0, 1'b0);   // sb
        do_req(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 1'b0);           // lw
        do_req(1'b0, 3'b010, 32'h102, 32'h0, 1'b0, 1'b0);           // misaligned lw
        do_req(1'b0, 3'b011, 32'h100, 32'h0, 1'b0, 1'b0);           // illegal load
        do_req(1'b1, 3'b011, 32'h101, 32'h0, 1'b0, 1'b0);           // illegal beats misaligned
        do_req(1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 1'b0);           // back-to-back pair
        do_req(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b1);
        do_req(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 1'b0);

        // Reset in SAMPLE of a store must leave memory untouched
        wr0 = wr_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h100; req_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs();
        reset = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_no_write", wr_cnt - wr0, 0);
        do_req(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
            else if (we) f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd5;
            end
            do_req(we, f3, 32'h100 + 32'($urandom_range(0, 63)), $urandom, 1'b0, 1'b0);
        end
        check_eq("we_at_wrclk_bad", wr_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
